// File: rtl/credit_bank.sv
// credit_bank: debounced coin keys feed a saturating credit counter.
// One- and two-player start requests are arbitrated against the current credit count.
module credit_bank #(
  parameter int unsigned NUM_SLOTS        = 2,
  parameter int unsigned COINS_PER_CREDIT = 1,
  parameter int unsigned MAX_CREDITS      = 9,
  parameter int unsigned DEBOUNCE_CYCLES  = 16
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 standBy,
  input  logic [NUM_SLOTS-1:0] keyCoinN,
  input  logic                 freePlay,
  input  logic                 startReq,
  input  logic                 startPlayers,
  output logic                 startGrant,
  output logic                 startDeny,
  output logic [NUM_SLOTS-1:0] coinAccepted,
  output logic [NUM_SLOTS-1:0] coinRejected,
  output logic [3:0]           credits,
  output logic [2:0]           coinPartial,
  output logic                 coinLockout
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] MAX_C = 4'(MAX_CREDITS);
  localparam logic [3:0] CPC_C = 4'(COINS_PER_CREDIT);

  typedef enum logic [2:0] {
    ARM         = 3'd0,
    IDLE        = 3'd1,
    PRESS_CNT   = 3'd2,
    HELD        = 3'd3,
    RELEASE_CNT = 3'd4
  } dbState_t;

  logic [NUM_SLOTS-1:0] pressEvt;
  logic [NUM_SLOTS-1:0] pending;
  logic [NUM_SLOTS-1:0] pendingNext;
  logic [NUM_SLOTS-1:0] svcOneHot;
  logic [NUM_SLOTS-1:0] acceptNext;
  logic [NUM_SLOTS-1:0] rejectNext;
  logic [2:0]           partialNext;
  logic [3:0]           creditsNext;
  logic [3:0]           cost;
  logic [3:0]           dec;
  logic                 inc;
  logic                 grantNext;
  logic                 denyNext;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : gSlot
    logic [1:0]       syncQ;
    logic             sample;
    dbState_t         state;
    dbState_t         stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             evt;

    // Two-flop synchronizer for the asynchronous key, idles high
    always_ff @(posedge clk or posedge resetN) begin
      if (resetN) syncQ <= 2'b11;
      else        syncQ <= {syncQ[0], keyCoinN[g]};
    end

    assign sample = syncQ[1];

    // Debounce state and run-length counter
    always_ff @(posedge clk or posedge resetN) begin
      if (resetN) begin
        state <= ARM;
        cnt   <= '0;
      end else begin
        state <= stateNext;
        cnt   <= cntNext;
      end
    end

    // Debounce next state: a press counts only after a stable release and a stable fresh press
    always_comb begin
      stateNext = state;
      cntNext   = cnt;
      case (state)
        ARM: begin
          if (sample) begin
            if (cnt == LAST_CNT) begin
              stateNext = IDLE;
              cntNext   = '0;
            end else begin
              cntNext = cnt + CNT_W'(1);
            end
          end else begin
            cntNext = '0;
          end
        end
        IDLE: begin
          if (!sample) begin
            stateNext = PRESS_CNT;
            cntNext   = CNT_W'(1);
          end
        end
        PRESS_CNT: begin
          if (!sample) begin
            if (cnt == LAST_CNT) begin
              stateNext = HELD;
              cntNext   = '0;
            end else begin
              cntNext = cnt + CNT_W'(1);
            end
          end else begin
            stateNext = IDLE;
            cntNext   = '0;
          end
        end
        HELD: begin
          if (sample) begin
            stateNext = RELEASE_CNT;
            cntNext   = CNT_W'(1);
          end
        end
        RELEASE_CNT: begin
          if (sample) begin
            if (cnt == LAST_CNT) begin
              stateNext = IDLE;
              cntNext   = '0;
            end else begin
              cntNext = cnt + CNT_W'(1);
            end
          end else begin
            stateNext = HELD;
            cntNext   = '0;
          end
        end
        default: begin
          stateNext = ARM;
          cntNext   = '0;
        end
      endcase
    end

    // Debounce output: one-cycle event on the last qualifying low sample
    always_comb begin
      evt = 1'b0;
      if (state == PRESS_CNT && !sample && cnt == LAST_CNT) evt = 1'b1;
    end

    assign pressEvt[g] = evt;
  end

  // Coin arbitration, credit arithmetic and start decision, all from pre-cycle credits
  always_comb begin
    svcOneHot   = '0;
    acceptNext  = '0;
    rejectNext  = '0;
    partialNext = coinPartial;
    inc         = 1'b0;
    dec         = 4'd0;
    cost        = startPlayers ? 4'd2 : 4'd1;
    grantNext   = 1'b0;
    denyNext    = 1'b0;
    pendingNext = pending;
    if (!standBy) begin
      svcOneHot = pending & (~pending + NUM_SLOTS'(1));
      if (|pending) begin
        if (credits < MAX_C) begin
          acceptNext = svcOneHot;
          if (4'(coinPartial) + 4'd1 == CPC_C) begin
            partialNext = 3'd0;
            inc         = 1'b1;
          end else begin
            partialNext = coinPartial + 3'd1;
          end
        end else begin
          rejectNext = svcOneHot;
        end
      end
      if (startReq) begin
        if (freePlay) begin
          grantNext = 1'b1;
        end else if (credits >= cost) begin
          grantNext = 1'b1;
          dec       = cost;
        end else begin
          denyNext = 1'b1;
        end
      end
      // A press arriving while its slot is still pending is merged into it
      pendingNext = (pending & ~svcOneHot) | (pressEvt & ~pending);
    end
    creditsNext = credits + 4'(inc) - dec;
  end

  // Registered state and outputs
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      pending      <= '0;
      coinAccepted <= '0;
      coinRejected <= '0;
      coinPartial  <= 3'd0;
      credits      <= 4'd0;
      coinLockout  <= 1'b0;
      startGrant   <= 1'b0;
      startDeny    <= 1'b0;
    end else begin
      pending      <= pendingNext;
      coinAccepted <= acceptNext;
      coinRejected <= rejectNext;
      coinPartial  <= partialNext;
      credits      <= creditsNext;
      coinLockout  <= (creditsNext == MAX_C);
      startGrant   <= grantNext;
      startDeny    <= denyNext;
    end
  end

endmodule

// File: tb/tb_credit_bank.sv
// Directed bench for credit_bank: 2 slots, 2 coins per credit, max 9 credits, 16-sample debounce.
module tb_credit_bank;

  logic       clk;
  logic       rst;
  logic       standBy;
  logic [1:0] keyCoinN;
  logic       freePlay;
  logic       startReq;
  logic       startPlayers;
  logic       startGrant;
  logic       startDeny;
  logic [1:0] coinAccepted;
  logic [1:0] coinRejected;
  logic [3:0] credits;
  logic [2:0] coinPartial;
  logic       coinLockout;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int acc0 = 0, acc1 = 0, rej0 = 0, rej1 = 0;
  int accCyc0 = 0, accCyc1 = 0;

  credit_bank #(
    .NUM_SLOTS(2), .COINS_PER_CREDIT(2), .MAX_CREDITS(9), .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk), .resetN(rst), .standBy(standBy), .keyCoinN(keyCoinN),
    .freePlay(freePlay), .startReq(startReq), .startPlayers(startPlayers),
    .startGrant(startGrant), .startDeny(startDeny),
    .coinAccepted(coinAccepted), .coinRejected(coinRejected),
    .credits(credits), .coinPartial(coinPartial), .coinLockout(coinLockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tally coin pulses at the inactive edge
  always @(negedge clk) begin
    if (!rst) begin
      if (coinAccepted[0]) begin acc0 = acc0 + 1; accCyc0 = cyc; end
      if (coinAccepted[1]) begin acc1 = acc1 + 1; accCyc1 = cyc; end
      if (coinRejected[0]) rej0 = rej0 + 1;
      if (coinRejected[1]) rej1 = rej1 + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    nChecks = nChecks + 1;
    if (got == exp) nPass = nPass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Press the masked keys cleanly, then release long enough to re-arm
  task automatic pressKeys(input logic [1:0] mask);
    keyCoinN = ~mask;
    repeat (24) @(negedge clk);
    keyCoinN = 2'b11;
    repeat (24) @(negedge clk);
  endtask

  // One start request pulse, checking the response in the following cycle
  task automatic startOnce(input string tag, input logic players, input int expG,
                           input int expD, input int expC);
    startReq     = 1'b1;
    startPlayers = players;
    @(negedge clk);
    startReq = 1'b0;
    check({tag, "_grant"}, int'(startGrant), expG);
    check({tag, "_deny"}, int'(startDeny), expD);
    check({tag, "_credits"}, int'(credits), expC);
    @(negedge clk);
    check({tag, "_pulse_end"}, int'(startGrant | startDeny), 0);
  endtask

  initial begin
    rst = 1'b1; standBy = 1'b0; keyCoinN = 2'b10; freePlay = 1'b0;
    startReq = 1'b0; startPlayers = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_credits", int'(credits), 0);
    check("rst_partial", int'(coinPartial), 0);
    check("rst_lockout", int'(coinLockout), 0);
    check("rst_accepted", int'(coinAccepted), 0);
    check("rst_start", int'(startGrant | startDeny), 0);

    // Key 0 held through reset must not count
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("held_through_reset", acc0, 0);
    keyCoinN = 2'b11;
    repeat (24) @(negedge clk);
    check("release_after_reset", acc0, 0);

    // Two coins per credit: partial 1,0,1 and credits 0,1,1
    pressKeys(2'b01);
    check("p1_acc0", acc0, 1);
    check("p1_partial", int'(coinPartial), 1);
    check("p1_credits", int'(credits), 0);
    pressKeys(2'b01);
    check("p2_partial", int'(coinPartial), 0);
    check("p2_credits", int'(credits), 1);
    pressKeys(2'b01);
    check("p3_acc0", acc0, 3);
    check("p3_partial", int'(coinPartial), 1);
    check("p3_credits", int'(credits), 1);

    // Both slots debounce together: slot 0 served first, slot 1 on the next cycle
    pressKeys(2'b11);
    check("dual_acc0", acc0, 4);
    check("dual_acc1", acc1, 1);
    check("dual_order", accCyc1 - accCyc0, 1);
    check("dual_credits", int'(credits), 2);
    check("dual_partial", int'(coinPartial), 1);

    // Fill to saturation: six dual presses to 8 credits, one more coin to 9
    repeat (6) pressKeys(2'b11);
    check("fill_credits", int'(credits), 8);
    check("fill_lockout_low", int'(coinLockout), 0);
    pressKeys(2'b01);
    check("sat_credits", int'(credits), 9);
    check("sat_partial", int'(coinPartial), 0);
    check("sat_lockout", int'(coinLockout), 1);

    // Coin at saturation is rejected and leaves partial alone
    pressKeys(2'b10);
    check("rej_rej1", rej1, 1);
    check("rej_rej0", rej0, 0);
    check("rej_acc1", acc1, 7);
    check("rej_credits", int'(credits), 9);
    check("rej_partial", int'(coinPartial), 0);
    check("rej_lockout", int'(coinLockout), 1);

    // Back-to-back two-player starts: 9 -> 7 -> 5 -> 3 -> 1
    startReq = 1'b1;
    startPlayers = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("b2b_grant", int'(startGrant), 1);
      check("b2b_credits", int'(credits), 7 - 2 * k);
    end
    startReq = 1'b0;
    @(negedge clk);
    check("b2b_lockout", int'(coinLockout), 0);

    startOnce("two_at_1", 1'b1, 0, 1, 1);
    startOnce("one_at_1", 1'b0, 1, 0, 0);
    startOnce("one_at_0", 1'b0, 0, 1, 0);

    freePlay = 1'b1;
    startOnce("freeplay", 1'b1, 1, 0, 0);
    freePlay = 1'b0;

    standBy = 1'b1;
    startOnce("standby", 1'b0, 0, 0, 0);
    standBy = 1'b0;

    // Five-cycle glitch is shorter than the debounce window
    keyCoinN = 2'b10;
    repeat (5) @(negedge clk);
    keyCoinN = 2'b11;
    repeat (40) @(negedge clk);
    check("glitch_acc0", acc0, 11);
    check("glitch_credits", int'(credits), 0);
    check("glitch_partial", int'(coinPartial), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/credit_bank.md
# credit_bank

Parametrised coin/credit bank for the start screen. It debounces NUM_SLOTS active-low coin keys and queues their presses. Coins are converted to credits at a configurable coins-per-credit rate, with a saturating credit counter. One- or two-player start requests are arbitrated with a grant/deny pulse pair. It sits between the raw key inputs and the start-screen credit display and game-start logic.

## Interface
Parameters:
- NUM_SLOTS, 2, number of coin keys (1..4)
- COINS_PER_CREDIT, 1, coins needed per credit (1..8)
- MAX_CREDITS, 9, saturation value of credits (1..15)
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a level change (>=2)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous reset, active-high
- standBy  in  1  high: coin and start inputs ignored, state held
- keyCoinN  in  NUM_SLOTS  raw coin keys, active-low, asynchronous
- freePlay  in  1  high: starts granted without consuming credits
- startReq  in  1  one-cycle start request pulse
- startPlayers  in  1  0 = one player (cost 1), 1 = two players (cost 2)
- startGrant  out  1  one-cycle pulse, start accepted
- startDeny  out  1  one-cycle pulse, start refused
- coinAccepted  out  NUM_SLOTS  one-cycle pulse per slot, coin counted
- coinRejected  out  NUM_SLOTS  one-cycle pulse per slot, coin dropped at saturation
- credits  out  4  current credit count
- coinPartial  out  3  coins collected toward the next credit (0..COINS_PER_CREDIT-1)
- coinLockout  out  1  high while credits == MAX_CREDITS

## Operation
- Per-slot input path: a 2-flop synchronizer (reset to 1) feeds a debounce FSM.
  - ARM: requires DEBOUNCE_CYCLES consecutive high samples, then goes to IDLE. Any low sample restarts the count.
  - IDLE: a low sample goes to PRESS_CNT.
  - PRESS_CNT: counts consecutive low samples. On the DEBOUNCE_CYCLES-th it sets the slot's pending bit and goes to HELD. A high sample returns to IDLE and counts nothing.
  - HELD: a high sample goes to RELEASE_CNT.
  - RELEASE_CNT: DEBOUNCE_CYCLES consecutive high samples go to IDLE. A low sample returns to HELD.
- Reset enters ARM, so a key held through reset is never counted. A press is only counted after a release and a fresh press.
- Each slot has one pending bit. A second debounced press while still pending is merged, so that coin is lost.
- Arbiter: each cycle, the lowest-index pending slot is serviced and its pending bit cleared.
  - If credits < MAX_CREDITS: pulse coinAccepted[i] and set coinPartial+1.
  - If coinPartial+1 == COINS_PER_CREDIT: set coinPartial to 0 and credits+1.
  - If credits == MAX_CREDITS: pulse coinRejected[i]; coinPartial is unchanged.
- Start, on a startReq sample:
  - freePlay = 1: startGrant; credits unchanged.
  - Else credits >= cost: startGrant and credits-cost.
  - Else: startDeny; credits unchanged.
- startPlayers is sampled with startReq. coinPartial is never consumed by a start.
- Same-cycle coin service and start:
  - Both decisions use the pre-cycle credits value.
  - Result is credits + inc - dec.
  - A coin at saturation is rejected even if the same-cycle start frees room.
- standBy = 1:
  - Synchronizers and debounce FSMs keep running.
  - Pending bits hold; the arbiter does not service.
  - startReq is ignored, with no grant or deny.
- credits never exceeds MAX_CREDITS and never underflows.

## Timing
- Reset values: all outputs 0; pending bits 0; FSMs in ARM; synchronizers 1.
- Key low-going edge to pending set: 2 sync cycles + DEBOUNCE_CYCLES samples.
- Pending set to coinAccepted/coinRejected pulse: 1 cycle, if highest priority and standBy is low.
- credits, coinPartial and coinLockout update on the same edge as the coinAccepted pulse.
- startReq sampled on edge N gives startGrant/startDeny high during cycle N+1, with credits updated on edge N+1.
- Back-to-back startReq: each one is evaluated against the credits produced by the previous one.
- All outputs are registered. Reset asserted mid-operation clears everything immediately; pulses in flight are lost.

## Test plan
- Reset with keyCoinN[0] held low, then released and re-pressed for 20 cycles (DEBOUNCE_CYCLES=16) -> a single coinAccepted[0] and credits = 1. No count while the key was held through reset.
- COINS_PER_CREDIT=2, three clean presses on slot 0 -> coinPartial 1, 0, 1; credits 0, 1, 1.
- Slots 0 and 1 debounced on the same cycle -> coinAccepted[0] on cycle k, coinAccepted[1] on cycle k+1, credits +2.
- credits = 9 = MAX_CREDITS, press slot 1 -> coinRejected[1] pulse, credits stays 9, coinLockout = 1.
- credits = 1, startReq with startPlayers = 1 -> startDeny, credits stays 1. Then startPlayers = 0 -> startGrant, credits = 0.
- freePlay = 1, credits = 0, startReq -> startGrant, credits stays 0. Glitch pulse of 5 cycles on keyCoinN -> no coin counted.
